// File: rtl/ifmap_weight_feeder_4x6_pkg.sv
// ifmap_weight_feeder_4x6_pkg: shared sizes, FSM states and constants for the 4x6 feeder
package ifmap_weight_feeder_4x6_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 6;
  localparam int DW = 16;
  localparam int NW = ROWS * COLS;
  localparam logic [4:0] W_LAST = 5'(NW - 1);
  localparam logic [3:0] DRAIN_LEN = 4'(ROWS + COLS);
  localparam logic [DW-1:0] FP16_ZERO = 16'h0000;
  typedef enum logic [1:0] {LOAD_W, COMMIT, STREAM, DRAIN} state_t;
endpackage

// File: rtl/ifmap_weight_feeder_4x6_skew_delay_line.sv
// skew_delay_line: one ifmap lane delayed DEPTH cycles, cleared to +0 on reset
module skew_delay_line #(
  parameter int DW = 16,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] sr [DEPTH];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
    end else begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/ifmap_weight_feeder_4x6.sv
// ifmap_weight_feeder_4x6: loads 24 weights, streams row-skewed ifmap beats, drains and tags south psum validity
module ifmap_weight_feeder_4x6
  import ifmap_weight_feeder_4x6_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DW-1:0]           w_data,
  input  logic                    reuse_w,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [ROWS*DW-1:0]      s_data,
  input  logic                    s_last,
  output logic                    load_en,
  output logic [ROWS*COLS*DW-1:0] weights_out,
  output logic [ROWS*DW-1:0]      ifmap_west_out,
  output logic [COLS-1:0]         south_valid,
  output logic                    tile_done,
  output logic                    busy
);
  state_t state, state_nx;
  logic [4:0] w_cnt;
  logic [3:0] d_cnt;
  logic [ROWS+COLS-1:0] vsr;
  logic w_acc, s_acc;
  assign w_acc = w_valid && w_ready;
  assign s_acc = s_valid && s_ready;
  always_comb begin
    state_nx = state;
    w_ready = state == LOAD_W;
    s_ready = state == STREAM;
    load_en = state == COMMIT;
    tile_done = state == DRAIN && d_cnt == 4'd1;
    busy = !(state == LOAD_W && w_cnt == '0);
    case (state)
      LOAD_W: state_nx = w_valid && w_cnt == W_LAST ? COMMIT : LOAD_W;
      COMMIT: state_nx = STREAM;
      STREAM: state_nx = s_valid && s_last ? DRAIN : STREAM;
      DRAIN:  state_nx = tile_done ? (reuse_w ? STREAM : LOAD_W) : DRAIN;
      default: state_nx = LOAD_W;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD_W;
      w_cnt <= '0;
      d_cnt <= '0;
      vsr <= '0;
      weights_out <= '0;
    end else begin
      state <= state_nx;
      if (w_acc) begin
        weights_out[w_cnt*DW +: DW] <= w_data;
        w_cnt <= w_cnt == W_LAST ? 5'd0 : w_cnt + 5'd1;
      end
      d_cnt <= s_acc && s_last ? DRAIN_LEN : (state == DRAIN ? d_cnt - 4'd1 : d_cnt);
      vsr <= {vsr[ROWS+COLS-2:0], s_acc};
    end
  end
  // a beat's valid reaches psum column j after ROWS+j+1 cycles
  assign south_valid = vsr[ROWS+COLS-1:ROWS];
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    skew_delay_line #(.DW(DW), .DEPTH(1 + i)) u_skew (
      .clk(clk),
      .rst(rst),
      .din(s_acc ? s_data[i*DW +: DW] : FP16_ZERO),
      .dout(ifmap_west_out[i*DW +: DW])
    );
  end
endmodule
